// File: rtl/uart_tx_pct.sv
// 8N1 UART transmitter for the pass-percentage byte, with a one-byte holding
// register so a second request can queue behind the frame on the line.
module uart_tx_pct #(
   parameter int unsigned CLKS_PER_BIT = 78
) (
   input  logic       clk9MHz,
   input  logic       rst,
   input  logic       to_uart_valid,
   input  logic [7:0] to_uart_data,
   output logic       uart_txd,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_overflow
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);

   state_t      state_reg, state_next;
   logic [15:0] cnt_reg, cnt_next;
   logic [2:0]  bit_reg, bit_next;
   logic [7:0]  shift_reg, shift_next;
   logic [7:0]  hold_reg, hold_next;
   logic        full_reg, full_next;
   logic        ovf_reg, ovf_next;
   logic        txd_reg, txd_next;
   logic        bit_end;
   logic        last_stop;

   assign bit_end   = (cnt_reg == CNT_LAST);
   assign last_stop = (state_reg == S_STOP) && bit_end;

   always_ff @(posedge clk9MHz or negedge rst) begin
      if (!rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (to_uart_valid) state_next = S_START;
         S_START: if (bit_end) state_next = S_DATA;
         S_DATA:  if (bit_end && (bit_reg == 3'd7)) state_next = S_STOP;
         S_STOP: begin
            // A byte waiting in holding, or arriving right now, chains
            // straight into the next start bit without an idle cycle.
            if (bit_end) state_next = (full_reg || to_uart_valid) ? S_START : S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Line level is computed from the next state so uart_txd can be a flop.
   always_comb begin
      txd_next = 1'b1;
      case (state_next)
         S_START: txd_next = 1'b0;
         S_DATA:  txd_next = shift_reg[bit_next];
         default: txd_next = 1'b1;
      endcase
      tx_busy = (state_reg != S_IDLE) || full_reg;
      tx_done = last_stop;
   end

   always_comb begin
      cnt_next   = ((state_reg == S_IDLE) || bit_end) ? 16'd0 : cnt_reg + 16'd1;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      hold_next  = hold_reg;
      full_next  = full_reg;
      ovf_next   = ovf_reg;
      if ((state_reg == S_DATA) && bit_end) begin
         bit_next = bit_reg + 3'd1;
      end
      if (state_reg == S_IDLE) begin
         if (to_uart_valid) shift_next = to_uart_data;
      end else if (last_stop) begin
         // Drain holding into the shifter; a coincident request refills it.
         if (full_reg) begin
            shift_next = hold_reg;
            if (to_uart_valid) begin
               hold_next = to_uart_data;
            end else begin
               full_next = 1'b0;
            end
         end else if (to_uart_valid) begin
            shift_next = to_uart_data;
         end
      end else if (to_uart_valid) begin
         if (full_reg) begin
            ovf_next = 1'b1;
         end else begin
            hold_next = to_uart_data;
            full_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk9MHz or negedge rst) begin
      if (!rst) begin
         cnt_reg   <= 16'd0;
         bit_reg   <= 3'd0;
         shift_reg <= 8'h00;
         hold_reg  <= 8'h00;
         full_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
         txd_reg   <= 1'b1;
      end else begin
         cnt_reg   <= cnt_next;
         bit_reg   <= bit_next;
         shift_reg <= shift_next;
         hold_reg  <= hold_next;
         full_reg  <= full_next;
         ovf_reg   <= ovf_next;
         txd_reg   <= txd_next;
      end
   end

   assign uart_txd    = txd_reg;
   assign tx_overflow = ovf_reg;

endmodule

// File: tb/tb_uart_tx_pct.sv
// Bench for uart_tx_pct: directed scenarios plus random requests, checked
// every cycle against a frame-schedule model of the expected line activity.
module tb_uart_tx_pct;

   localparam int C     = 4;
   localparam int FRAME = 10 * C;

   logic       clk9MHz = 1'b0;
   logic       rst = 1'b1;
   logic       to_uart_valid = 1'b0;
   logic [7:0] to_uart_data = 8'h00;
   logic       uart_txd, tx_busy, tx_done, tx_overflow;

   logic       v78 = 1'b0;
   logic [7:0] d78 = 8'h00;
   logic       txd78, busy78, done78, ovf78;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   bit mon_en = 1'b0;

   // Model: every accepted byte becomes a frame with a known start cycle.
   int         q_start[$];
   logic [7:0] q_byte[$];
   int         ovf_at = -1;

   uart_tx_pct #(.CLKS_PER_BIT(C)) dut (
      .clk9MHz(clk9MHz), .rst(rst),
      .to_uart_valid(to_uart_valid), .to_uart_data(to_uart_data),
      .uart_txd(uart_txd), .tx_busy(tx_busy),
      .tx_done(tx_done), .tx_overflow(tx_overflow)
   );

   uart_tx_pct dut78 (
      .clk9MHz(clk9MHz), .rst(rst),
      .to_uart_valid(v78), .to_uart_data(d78),
      .uart_txd(txd78), .tx_busy(busy78),
      .tx_done(done78), .tx_overflow(ovf78)
   );

   always #5 clk9MHz = ~clk9MHz;
   always @(posedge clk9MHz) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic void model_clear();
      q_start.delete();
      q_byte.delete();
      ovf_at = -1;
   endfunction

   function automatic void model_req(input int n, input logic [7:0] d);
      int pending  = 0;
      int last_end = -1;
      int start;
      foreach (q_start[i]) if (q_start[i] > n) pending++;
      if (q_start.size() > 0) last_end = q_start[q_start.size()-1] + FRAME - 1;
      if (pending == 0)
         start = (n + 1 > last_end + 1) ? n + 1 : last_end + 1;
      else if (pending == 1 && q_start[q_start.size()-1] == n + 1)
         start = last_end + 1;
      else
         start = -1;
      if (start < 0) begin
         if (ovf_at < 0) ovf_at = n + 1;
         $display("cycle %0d: request 0x%02h dropped (holding full)", n, d);
      end else begin
         q_start.push_back(start);
         q_byte.push_back(d);
         $display("cycle %0d: request 0x%02h accepted, frame starts cycle %0d", n, d, start);
      end
   endfunction

   function automatic logic exp_txd(input int t);
      foreach (q_start[i]) begin
         if (t >= q_start[i] && t < q_start[i] + FRAME) begin
            int k = (t - q_start[i]) / C;
            logic [7:0] b = q_byte[i];
            if (k == 0) return 1'b0;
            if (k == 9) return 1'b1;
            return b[k-1];
         end
      end
      return 1'b1;
   endfunction

   function automatic logic exp_busy(input int t);
      foreach (q_start[i]) if (t >= q_start[i] && t < q_start[i] + FRAME) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic exp_done(input int t);
      foreach (q_start[i]) if (t == q_start[i] + FRAME - 1) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic exp_ovf(input int t);
      return (ovf_at >= 0) && (t >= ovf_at);
   endfunction

   always @(negedge clk9MHz) begin
      if (mon_en) begin
         chk("txd", uart_txd, exp_txd(cyc));
         chk("busy", tx_busy, exp_busy(cyc));
         chk("done", tx_done, exp_done(cyc));
         chk("ovf", tx_overflow, exp_ovf(cyc));
      end
   end

   task automatic step();
      @(posedge clk9MHz);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) step();
   endtask

   task automatic send(input logic [7:0] d);
      to_uart_valid = 1'b1;
      to_uart_data  = d;
      model_req(cyc, d);
      step();
      to_uart_valid = 1'b0;
      to_uart_data  = 8'($urandom);
   endtask

   // Asserted just after an edge; checks the asynchronous effect at once.
   task automatic do_reset();
      rst = 1'b0;
      model_clear();
      #1;
      chk("rst_txd", uart_txd, 1'b1);
      chk("rst_busy", tx_busy, 1'b0);
      chk("rst_done", tx_done, 1'b0);
      chk("rst_ovf", tx_overflow, 1'b0);
      repeat (3) @(posedge clk9MHz);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int lowcnt;
      int bound;
      #1;
      do_reset();
      mon_en = 1'b1;

      // Single byte
      base = cyc;
      wait_until(base + 10); send(8'h5A);
      wait_until(base + 11); chk("s1_start", uart_txd, 1'b0);
      wait_until(base + 50); chk("s1_done", tx_done, 1'b1);
      wait_until(base + 51); chk("s1_idle", tx_busy, 1'b0);

      // Back-to-back through holding register
      do_reset(); base = cyc;
      wait_until(base + 10); send(8'h64);
      wait_until(base + 20); send(8'h01);
      wait_until(base + 51); chk("s2_start2", uart_txd, 1'b0);
      chk("s2_busy", tx_busy, 1'b1);
      wait_until(base + 95); chk("s2_ovf", tx_overflow, 1'b0);

      // Overflow
      do_reset(); base = cyc;
      wait_until(base + 10); send(8'h11);
      wait_until(base + 20); send(8'h22);
      wait_until(base + 30); chk("s3_ovf_pre", tx_overflow, 1'b0); send(8'h33);
      chk("s3_ovf_set", tx_overflow, 1'b1);
      wait_until(base + 140); chk("s3_ovf_sticky", tx_overflow, 1'b1);

      // Request on the last stop cycle, holding empty
      do_reset(); base = cyc;
      wait_until(base + 10); send(8'hA5);
      wait_until(base + 50); send(8'hC3);
      chk("s4_start", uart_txd, 1'b0);
      wait_until(base + 95); chk("s4_ovf", tx_overflow, 1'b0);

      // Request on the last stop cycle, holding full: drain and refill
      do_reset(); base = cyc;
      wait_until(base + 10); send(8'h11);
      wait_until(base + 20); send(8'h22);
      wait_until(base + 50); send(8'h33);
      wait_until(base + 91); chk("s5_third", uart_txd, 1'b0);
      wait_until(base + 135); chk("s5_ovf", tx_overflow, 1'b0);

      // Reset mid-frame then immediate new request
      do_reset(); base = cyc;
      wait_until(base + 10); send(8'hFF);
      wait_until(base + 25);
      rst = 1'b0;
      model_clear();
      #1;
      chk("s6_txd", uart_txd, 1'b1);
      chk("s6_busy", tx_busy, 1'b0);
      repeat (3) @(posedge clk9MHz);
      #1;
      rst = 1'b1;
      send(8'h3C);
      wait_until(cyc + 45);

      // Random traffic, with one reset in the middle
      do_reset();
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 19) == 0) send(8'($urandom));
         else begin
            to_uart_data = 8'($urandom);
            step();
         end
         if (i == 1200) do_reset();
      end
      wait_until(cyc + 150);

      // Default bit period on the second instance
      chk("d78_idle", txd78, 1'b1);
      v78 = 1'b1;
      d78 = 8'h00;
      $display("cycle %0d: default-rate request 0x00", cyc);
      step();
      v78 = 1'b0;
      d78 = 8'hFF;
      lowcnt = 0;
      bound = 0;
      while (txd78 == 1'b0 && bound < 2000) begin
         lowcnt++;
         bound++;
         step();
      end
      chk("d78_low", lowcnt, 702);
      chk("d78_high", txd78, 1'b1);
      repeat (78) step();
      chk("d78_busy", busy78, 1'b0);

      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
